// File: rtl/tempo_pkg.sv
// Shared constants for the MM:SS seven-segment display: FSM encoding, divider and
// clamp limits, and the active-low segment patterns.
package tempo_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DIV,
      ST_CLAMP,
      ST_BCD,
      ST_DONE
   } state_t;

   localparam logic [6:0] DIVISOR = 7'd60;
   localparam logic [6:0] MAX_MIN = 7'd99;
   localparam logic [6:0] MAX_SEC = 7'd59;

   // Segment order {g,f,e,d,c,b,a}, a zero bit lights the segment
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;

   // Double-dabble correction applied to each BCD nibble before the shift
   function automatic logic [3:0] adj3(input logic [3:0] n);
      return (n >= 4'd5) ? n + 4'd3 : n;
   endfunction

endpackage

// File: rtl/bcd_para_7seg.sv
// Combinational BCD digit to active-low seven-segment pattern; non-decimal codes blank.
module bcd_para_7seg
   import tempo_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (bcd)
         4'd0: seg = SEG_0;
         4'd1: seg = SEG_1;
         4'd2: seg = SEG_2;
         4'd3: seg = SEG_3;
         4'd4: seg = SEG_4;
         4'd5: seg = SEG_5;
         4'd6: seg = SEG_6;
         4'd7: seg = SEG_7;
         4'd8: seg = SEG_8;
         4'd9: seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/display_tempo.sv
// Converts a seconds count to MM:SS (sequential divide-by-60 plus double dabble) and
// scans the four digits onto a multiplexed active-low seven-segment display.
module display_tempo
   import tempo_pkg::*;
#(
   parameter int CLK_HZ  = 50_000_000,
   parameter int SCAN_HZ = 1_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] segundos,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic        busy,
   output logic        overflow
);

   localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
   localparam int CW       = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

   state_t      state;
   logic [15:0] last_val;
   logic        valid;
   logic [15:0] div_q;
   logic [6:0]  rem;
   logic [3:0]  step;
   logic [6:0]  min_bin, sec_bin;
   logic [7:0]  min_bcd, sec_bcd;
   logic        ovf_pend;
   logic [3:0]  dig_su, dig_st, dig_mu, dig_mt;

   // One restoring-division step: remainder shifts in the next dividend bit
   logic [6:0]  rem_sh, rem_nx;
   logic        q_bit;
   logic [7:0]  min_adj, sec_adj;
   logic [14:0] min_sh, sec_sh;

   always_comb begin
      rem_sh  = {rem[5:0], div_q[15]};
      q_bit   = (rem_sh >= DIVISOR);
      rem_nx  = q_bit ? (rem_sh - DIVISOR) : rem_sh;
      min_adj = {adj3(min_bcd[7:4]), adj3(min_bcd[3:0])};
      sec_adj = {adj3(sec_bcd[7:4]), adj3(sec_bcd[3:0])};
      min_sh  = {min_adj, min_bin} << 1;
      sec_sh  = {sec_adj, sec_bin} << 1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         last_val <= '0;
         valid    <= 1'b0;
         div_q    <= '0;
         rem      <= '0;
         step     <= '0;
         min_bin  <= '0;
         sec_bin  <= '0;
         min_bcd  <= '0;
         sec_bcd  <= '0;
         ovf_pend <= 1'b0;
         dig_su   <= '0;
         dig_st   <= '0;
         dig_mu   <= '0;
         dig_mt   <= '0;
         busy     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (!valid || segundos != last_val) begin
                  last_val <= segundos;
                  div_q    <= segundos;
                  rem      <= '0;
                  step     <= '0;
                  valid    <= 1'b1;
                  state    <= ST_DIV;
               end
            end
            ST_DIV: begin
               busy  <= 1'b1;
               div_q <= {div_q[14:0], q_bit};
               rem   <= rem_nx;
               step  <= step + 4'd1;
               if (step == 4'd15) state <= ST_CLAMP;
            end
            ST_CLAMP: begin
               if (div_q > 16'd99) begin
                  min_bin  <= MAX_MIN;
                  sec_bin  <= MAX_SEC;
                  ovf_pend <= 1'b1;
               end else begin
                  min_bin  <= div_q[6:0];
                  sec_bin  <= rem;
                  ovf_pend <= 1'b0;
               end
               min_bcd <= '0;
               sec_bcd <= '0;
               step    <= '0;
               state   <= ST_BCD;
            end
            ST_BCD: begin
               min_bcd <= min_sh[14:7];
               min_bin <= min_sh[6:0];
               sec_bcd <= sec_sh[14:7];
               sec_bin <= sec_sh[6:0];
               step    <= step + 4'd1;
               if (step == 4'd6) state <= ST_DONE;
            end
            ST_DONE: begin
               dig_mt   <= min_bcd[7:4];
               dig_mu   <= min_bcd[3:0];
               dig_st   <= sec_bcd[7:4];
               dig_su   <= sec_bcd[3:0];
               overflow <= ovf_pend;
               busy     <= 1'b0;
               state    <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Free-running digit scan; an, seg and dp are registered together
   logic [CW-1:0] scan_cnt;
   logic [1:0]    idx;
   logic [3:0]    cur_digit;
   logic [6:0]    dec_seg;

   always_comb begin
      cur_digit = dig_su;
      case (idx)
         2'd0: cur_digit = dig_su;
         2'd1: cur_digit = dig_st;
         2'd2: cur_digit = dig_mu;
         2'd3: cur_digit = dig_mt;
         default: cur_digit = dig_su;
      endcase
   end

   bcd_para_7seg u_dec (
      .bcd (cur_digit),
      .seg (dec_seg)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         scan_cnt <= '0;
         idx      <= '0;
         an       <= 4'b1111;
         seg      <= SEG_BLANK;
         dp       <= 1'b1;
      end else begin
         if (scan_cnt == CW'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            idx      <= idx + 2'd1;
         end else begin
            scan_cnt <= scan_cnt + CW'(1);
         end
         an  <= ~(4'b0001 << idx);
         seg <= dec_seg;
         dp  <= ~(idx == 2'd2);
      end
   end

endmodule

// File: tb/tb_display_tempo.sv
// Self-checking bench for display_tempo: table vectors, hand-written timing sequences
// and random values against an arithmetic MM:SS model.
module tb_display_tempo;

   logic        clk;
   logic        rst;
   logic [15:0] segundos;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic        busy;
   logic        overflow;

   int checks = 0;
   int errors = 0;

   logic [15:0] cur_digs;
   logic        cur_ovf;

   display_tempo #(.CLK_HZ(4), .SCAN_HZ(1)) dut (
      .clk      (clk),
      .rst      (rst),
      .segundos (segundos),
      .an       (an),
      .seg      (seg),
      .dp       (dp),
      .busy     (busy),
      .overflow (overflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [15:0] val;
      logic [15:0] digs;   // {min tens, min units, sec tens, sec units}
      logic        ovf;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %0h required %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [6:0] seg_of(input logic [3:0] d);
      logic [6:0] t [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                             7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
      return (d < 4'd10) ? t[d] : 7'h7F;
   endfunction

   task automatic model(input logic [15:0] v, output logic [15:0] digs, output logic ovf);
      int m, s;
      m = int'(v) / 60;
      s = int'(v) % 60;
      ovf = (m > 99);
      if (ovf) begin
         m = 99;
         s = 59;
      end
      digs = {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
   endtask

   function automatic int an_idx(input logic [3:0] a);
      case (a)
         4'b1110: return 0;
         4'b1101: return 1;
         4'b1011: return 2;
         4'b0111: return 3;
         default: return -1;
      endcase
   endfunction

   // Count scan cycles whose seg/dp disagree with the given digits
   function automatic int scan_bad(input logic [15:0] digs);
      int i;
      i = an_idx(an);
      if (i < 0) return 1;
      if (seg !== seg_of(digs[4*i +: 4])) return 1;
      if (dp !== (i != 2)) return 1;
      return 0;
   endfunction

   task automatic check_scan(input logic [15:0] digs, input int n, input string tag);
      int bad;
      bad = 0;
      for (int k = 0; k < n; k++) begin
         tick();
         bad += scan_bad(digs);
      end
      chk(tag, bad, 0);
   endtask

   // Caller has set up the input so the next posedge is the capture edge
   task automatic run_conv(input logic [15:0] digs, input logic ovf, input string tag);
      int busy_bad, old_bad;
      busy_bad = 0;
      old_bad  = 0;
      tick();
      if (busy !== 1'b0) busy_bad++;
      if (an_idx(an) >= 0) old_bad += scan_bad(cur_digs);
      for (int k = 1; k <= 25; k++) begin
         tick();
         if (busy !== (k <= 24)) busy_bad++;
         if (an_idx(an) >= 0) old_bad += scan_bad(cur_digs);
         if (k == 24) chk({tag, "_ovf_hold"}, overflow, cur_ovf);
         if (k == 25) chk({tag, "_ovf"}, overflow, ovf);
      end
      chk({tag, "_busy_window"}, busy_busy_fix(busy_bad), 0);
      chk({tag, "_old_digits"}, old_bad, 0);
      cur_digs = digs;
      cur_ovf  = ovf;
      tick();
      chk({tag, "_new_digit"}, scan_bad(digs), 0);
      check_scan(digs, 16, {tag, "_scan"});
   endtask

   function automatic int busy_busy_fix(input int b);
      return b;
   endfunction

   vec_t vecs [7];

   initial begin
      logic [15:0] d, v;
      logic        o;
      int          bad, run, changes;
      logic [3:0]  prev_an;
      logic        started;

      vecs[0] = '{16'd125,   16'h0205, 1'b0};
      vecs[1] = '{16'd5999,  16'h9959, 1'b0};
      vecs[2] = '{16'd6000,  16'h9959, 1'b1};
      vecs[3] = '{16'd65535, 16'h9959, 1'b1};
      vecs[4] = '{16'd3599,  16'h5959, 1'b0};
      vecs[5] = '{16'd1,     16'h0001, 1'b0};
      vecs[6] = '{16'd600,   16'h1000, 1'b0};

      // Reset held three cycles
      rst      = 1'b1;
      segundos = 16'd0;
      cur_digs = 16'h0000;
      cur_ovf  = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 3; k++) tick();
      chk("rst_an", an, 4'b1111);
      chk("rst_seg", seg, 7'h7F);
      chk("rst_dp", dp, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_ovf", overflow, 1'b0);
      rst = 1'b0;
      run_conv(16'h0000, 1'b0, "first_zero");

      // Table of fixed vectors
      for (int i = 0; i < 7; i++) begin
         segundos = vecs[i].val;
         run_conv(vecs[i].digs, vecs[i].ovf, $sformatf("vec%0d", i));
      end

      // Input changes mid-conversion: 59 then 60 at edge 5
      segundos = 16'd59;
      tick();
      for (int k = 1; k <= 4; k++) tick();
      segundos = 16'd60;
      for (int k = 5; k <= 25; k++) tick();
      chk("chg_busy25", busy, 1'b0);
      chk("chg_ovf", overflow, 1'b0);
      tick();
      chk("chg_busy26", busy, 1'b0);
      tick();
      chk("chg_busy27", busy, 1'b1);
      check_scan(16'h0059, 20, "chg_first_scan");
      for (int k = 48; k <= 50; k++) tick();
      chk("chg_busy50", busy, 1'b1);
      tick();
      chk("chg_busy51", busy, 1'b0);
      tick();
      check_scan(16'h0100, 16, "chg_second_scan");
      cur_digs = 16'h0100;

      // Scan order and dwell
      bad = 0; run = 0; changes = 0; started = 1'b0;
      prev_an = an;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (an !== prev_an) begin
            if (started && run != 4) bad++;
            if (an !== {prev_an[2:0], prev_an[3]}) bad++;
            started = 1'b1;
            changes++;
            run = 1;
         end else begin
            run++;
         end
         if ((dp === 1'b0) != (an === 4'b1011)) bad++;
         prev_an = an;
      end
      chk("scan_order_dwell", bad, 0);
      chk("scan_changes", (changes >= 9), 1'b1);

      // Random values against the arithmetic model
      v = 16'd60;
      for (int i = 0; i < 12; i++) begin
         logic [15:0] nv;
         do begin
            nv = (i % 2 == 0) ? 16'($urandom_range(0, 7000)) : 16'($urandom_range(0, 65535));
         end while (nv == v);
         v = nv;
         segundos = v;
         model(v, d, o);
         run_conv(d, o, $sformatf("rnd%0d_%0d", i, v));
      end

      // Reset during conversion of 3661, preceded by an overflowed value
      if (v != 16'd7000) begin
         segundos = 16'd7000;
         run_conv(16'h9959, 1'b1, "pre_rst");
      end
      segundos = 16'd3661;
      tick();
      for (int k = 1; k <= 9; k++) tick();
      rst = 1'b1;
      tick();
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_ovf", overflow, 1'b0);
      chk("midrst_an", an, 4'b1111);
      chk("midrst_seg", seg, 7'h7F);
      rst = 1'b0;
      cur_digs = 16'h0000;
      cur_ovf  = 1'b0;
      run_conv(16'h6101, 1'b0, "post_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
